ring_fifo_param: RTL and testbench
==================================

// Module: ring_fifo_param
// PURPOSE
//   Parametrised synchronous ring-buffer FIFO: next generation of the 4x8 ring buffer.
//   Configurable width, depth and read mode; adds occupancy count, programmable almost-flags,
//   same-cycle push+pop (including at full), synchronous flush and sticky overflow/underflow.
//   General-purpose elastic buffer between producer/consumer blocks in one clock domain.
// PARAMETERS
//   WIDTH     8   data width in bits (>=1)
//   DEPTH     16  entries (>=2; any value, non-power-of-2 allowed)
//   AF_LEVEL  12  almost_full asserts when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  2   almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
//   FWFT      0   0 = registered read (1-cycle latency); 1 = first-word-fall-through
// PORTS
//   clk           in   1                  clock, all state updates on rising edge
//   rst           in   1                  asynchronous reset, active-low
//   flush         in   1                  synchronous clear of contents and sticky flags
//   write_en      in   1                  push request
//   write_data    in   WIDTH              push data
//   read_en       in   1                  pop request
//   read_data     out  WIDTH              pop data (see BEHAVIOUR)
//   read_valid    out  1                  FWFT=0: pulse, read_data updated this cycle
//   full          out  1                  count == DEPTH
//   empty         out  1                  count == 0
//   almost_full   out  1                  count >= AF_LEVEL
//   almost_empty  out  1                  count <= AE_LEVEL
//   count         out  $clog2(DEPTH+1)    current occupancy
//   overflow      out  1                  sticky: push rejected since last clear
//   underflow     out  1                  sticky: pop rejected since last clear
// BEHAVIOUR
//   - Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, read_data=0, read_valid=0,
//     overflow=underflow=0; so empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0? n/a)=0.
//     Reset mid-operation discards all contents immediately; no partial pointer update.
//   - pop_ok  = read_en & ~empty.
//   - push_ok = write_en & (~full | pop_ok)  -> push+pop at full both succeed, count unchanged.
//   - Empty + push + pop: pop rejected (underflow set), push accepted, count -> 1.
//   - Pointers wrap explicitly: ptr == DEPTH-1 -> 0 (no reliance on power-of-2 overflow).
//   - count' = count + push_ok - pop_ok; flags derive combinationally from registered count.
//   - Rejected push: memory, pointers, count unchanged; overflow <= 1. Rejected pop: underflow <= 1.
//   - FWFT=0: on pop_ok edge read_data <= mem[rd_ptr], read_valid <= 1 for one cycle;
//     otherwise read_data holds last value, read_valid <= 0.
//   - FWFT=1: read_data = mem[rd_ptr] combinationally whenever ~empty (0 when empty);
//     read_en acts as acknowledge; read_valid = ~empty.
//   - Write to a slot and read of a different slot same cycle never conflict; at full with
//     push+pop, rd_ptr==wr_ptr: read returns old entry, write stores new (read-before-write).
//   - flush=1: pointers, count, sticky flags cleared next edge; flush overrides write_en/read_en
//     same cycle; read_data holds, read_valid <= 0.
// STRUCTURE
//   - Shared package ring_fifo_pkg: ptr-width/count-width helper functions, FWFT mode localparams.
//   - Sub-module ring_fifo_mem: DEPTH x WIDTH storage, 1 sync write port, 1 async read port.
//   - Top holds pointers, count, flag logic, read-data register; no other hierarchy.
// TESTING  (instance WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1, FWFT=0 unless noted)
//   1 push 10,20,30,40 -> full=1, count=4, almost_full from 3rd push; push 50 -> overflow=1,
//     count=4; pop x4 -> read_data 10,20,30,40 each with read_valid pulse; empty=1.
//   2 pop when empty -> underflow=1, read_data holds 40, read_valid=0, count=0.
//   3 wrap: push 100,200; pop(100); push 150,160,170; pop x4 -> 200,150,160,170; ptrs wrapped,
//     empty=1, no overflow set.
//   4 at full (1,2,3,4): push 5 + pop same cycle -> read_data=1, count=4, overflow=0; drain ->
//     2,3,4,5. Empty with push 9 + pop -> count=1, underflow=1.
//   5 push 7,8 then flush with write_en=1 -> count=0, empty=1, overflow/underflow=0, 8 not stored;
//     async rst pulse mid-sequence -> all outputs at reset values before next clk edge.
//   6 FWFT=1, DEPTH=5: push 11 -> read_data=11 same cycle after edge; fill 5 entries, wrap
//     twice, verify order and count vs. a reference queue model over 1000 random push/pop.

Source files
------------

// File: rtl/ring_fifo_pkg.sv
// Shared definitions for the ring_fifo family.
//   ptr_width()   : bits needed to address DEPTH entries
//   count_width() : bits needed to hold an occupancy of 0..DEPTH
//   FWFT_*        : read-mode selectors for the FWFT parameter
package ring_fifo_pkg;

  localparam int unsigned FWFT_REGISTERED  = 0;
  localparam int unsigned FWFT_FALLTHROUGH = 1;

  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned count_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ring_fifo_if.sv
// Producer/consumer bundle for ring_fifo_param.
//   master : drives flush, write_en/write_data, read_en; observes data and status
//   slave  : the FIFO side
interface ring_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  import ring_fifo_pkg::*;

  logic                            flush;
  logic                            write_en;
  logic [WIDTH-1:0]                write_data;
  logic                            read_en;
  logic [WIDTH-1:0]                read_data;
  logic                            read_valid;
  logic                            full;
  logic                            empty;
  logic                            almost_full;
  logic                            almost_empty;
  logic [count_width(DEPTH)-1:0]   count;
  logic                            overflow;
  logic                            underflow;

  modport master (
    output flush, write_en, write_data, read_en,
    input  read_data, read_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, write_en, write_data, read_en,
    output read_data, read_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/ring_fifo_mem.sv
// DEPTH x WIDTH storage for ring_fifo_param.
//   clk     : write clock
//   wr_en   : write strobe, wr_data stored at wr_addr on the rising edge
//   rd_addr : asynchronous read address, rd_data follows combinationally
// Contents are not reset; the owning FIFO never exposes an unwritten slot.
module ring_fifo_mem
  import ring_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [ptr_width(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic [ptr_width(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]              rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ring_fifo_param.sv
// Parametrised single-clock ring-buffer FIFO.
//   clk  : clock, all state on rising edge
//   rst  : asynchronous reset, active-low
//   bus  : ring_fifo_if slave (flush, write/read handshake, data, status flags)
// FWFT=0 gives a registered read with a one-cycle read_valid pulse per pop;
// FWFT=1 presents the head entry combinationally and read_en acknowledges it.
module ring_fifo_param
  import ring_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = FWFT_REGISTERED
) (
  input  logic       clk,
  input  logic       rst,
  ring_fifo_if.slave bus
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  typedef logic [PW-1:0] ptr_t;

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mem_rd_data;
  logic [WIDTH-1:0] read_data_q;
  logic             read_valid_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    pop_ok  = bus.read_en & ~empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    push_ok = bus.write_en & (~full | pop_ok);
  end

  ring_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok & ~bus.flush),
    .wr_addr (wr_ptr),
    .wr_data (bus.write_data),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else if (bus.flush) begin
      // read_data_q deliberately holds across a flush.
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      read_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
      if (bus.write_en & ~push_ok) overflow_q  <= 1'b1;
      if (bus.read_en  & ~pop_ok)  underflow_q <= 1'b1;
      // Memory read is taken before this edge's write, so at full with
      // push+pop on the same slot the old entry is returned.
      read_valid_q <= pop_ok & (FWFT == FWFT_REGISTERED);
      if (pop_ok && FWFT == FWFT_REGISTERED) read_data_q <= mem_rd_data;
    end
  end

  always_comb begin
    if (FWFT == FWFT_FALLTHROUGH) begin
      bus.read_data  = empty ? '0 : mem_rd_data;
      bus.read_valid = ~empty;
    end else begin
      bus.read_data  = read_data_q;
      bus.read_valid = read_valid_q;
    end
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_ring_fifo_param.sv
// Bench for ring_fifo_param: a registered-read 4-deep instance and a
// fall-through 5-deep instance, each scored against a queue of stored entries.
module tb_ring_fifo_param;
  import ring_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ring_fifo_if #(.WIDTH(8), .DEPTH(4)) a_if ();
  ring_fifo_if #(.WIDTH(8), .DEPTH(5)) b_if ();

  ring_fifo_param #(
    .WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(FWFT_REGISTERED)
  ) dut_a (.clk(clk), .rst(rst), .bus(a_if));

  ring_fifo_param #(
    .WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(FWFT_FALLTHROUGH)
  ) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [7:0] sa[$];
  logic [7:0] sb[$];
  bit         exp_rv;
  bit         exp_ovf;
  bit         exp_udf;
  logic [7:0] last_rd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle on instance A and updates the scoreboard with what
  // the FIFO should accept; the calling test does the comparisons.
  task automatic drive_a(input bit wr, input logic [7:0] d, input bit rd, input bit fl);
    bit pop_ok;
    bit push_ok;
    pop_ok  = rd && (sa.size() > 0);
    push_ok = wr && ((sa.size() < 4) || pop_ok);
    a_if.write_en   = wr;
    a_if.write_data = d;
    a_if.read_en    = rd;
    a_if.flush      = fl;
    if (fl) begin
      sa.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
      exp_rv  = 1'b0;
    end else begin
      if (wr && !push_ok) exp_ovf = 1'b1;
      if (rd && !pop_ok)  exp_udf = 1'b1;
      if (push_ok) sa.push_back(d);
      exp_rv = pop_ok;
    end
    tick();
    a_if.write_en = 1'b0;
    a_if.read_en  = 1'b0;
    a_if.flush    = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (a_if.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", a_if.empty); end
    checks++; if (a_if.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", a_if.full); end
    checks++; if (a_if.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", a_if.count); end
    checks++; if (a_if.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b want 1", a_if.almost_empty); end
    checks++; if (a_if.almost_full !== 1'b0) begin errors++; $display("FAIL reset_af: got %b want 0", a_if.almost_full); end
    checks++; if (a_if.read_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b want 0", a_if.read_valid); end
    checks++; if (a_if.read_data !== 8'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", a_if.read_data); end
    checks++; if (a_if.overflow !== 1'b0 || a_if.underflow !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b%b want 00", a_if.overflow, a_if.underflow); end
    checks++; if (b_if.empty !== 1'b1 || b_if.read_valid !== 1'b0 || b_if.read_data !== 8'd0) begin errors++; $display("FAIL reset_fwft: got empty=%b rv=%b rd=%0d want 1 0 0", b_if.empty, b_if.read_valid, b_if.read_data); end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] e;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 8'(10 * (i + 1)), 1'b0, 1'b0);
      checks++; if (int'(a_if.count) !== i + 1) begin errors++; $display("FAIL fill_count: got %0d want %0d", a_if.count, i + 1); end
      checks++; if (a_if.almost_full !== (i >= 2)) begin errors++; $display("FAIL fill_af: got %b want %b at push %0d", a_if.almost_full, (i >= 2), i + 1); end
    end
    checks++; if (a_if.full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", a_if.full); end
    drive_a(1'b1, 8'd50, 1'b0, 1'b0);
    checks++; if (a_if.overflow !== exp_ovf || exp_ovf !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b want 1", a_if.overflow); end
    checks++; if (a_if.count !== 3'd4) begin errors++; $display("FAIL overflow_count: got %0d want 4", a_if.count); end
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b0, 8'd0, 1'b1, 1'b0);
      checks++; if (a_if.read_valid !== exp_rv || exp_rv !== 1'b1) begin errors++; $display("FAIL drain_rv: got %b want 1", a_if.read_valid); end
      if (exp_rv) begin
        e = sa.pop_front();
        last_rd = e;
        checks++; if (a_if.read_data !== e) begin errors++; $display("FAIL drain_data: got %0d want %0d", a_if.read_data, e); end
      end
    end
    checks++; if (a_if.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", a_if.empty); end
  endtask

  task automatic test_underflow();
    drive_a(1'b0, 8'd0, 1'b1, 1'b0);
    checks++; if (a_if.underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b want 1", a_if.underflow); end
    checks++; if (a_if.read_data !== 8'd40) begin errors++; $display("FAIL underflow_hold: got %0d want 40", a_if.read_data); end
    checks++; if (a_if.read_valid !== 1'b0) begin errors++; $display("FAIL underflow_rv: got %b want 0", a_if.read_valid); end
    checks++; if (a_if.count !== 3'd0) begin errors++; $display("FAIL underflow_count: got %0d want 0", a_if.count); end
  endtask

  task automatic test_wrap();
    logic [7:0] pushes [5] = '{8'd100, 8'd200, 8'd150, 8'd160, 8'd170};
    logic [7:0] e;
    drive_a(1'b0, 8'd0, 1'b0, 1'b1);
    checks++; if (a_if.overflow !== 1'b0 || a_if.underflow !== 1'b0) begin errors++; $display("FAIL wrap_flush_sticky: got %b%b want 00", a_if.overflow, a_if.underflow); end
    drive_a(1'b1, pushes[0], 1'b0, 1'b0);
    drive_a(1'b1, pushes[1], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1 || i == 2 || i == 3) drive_a(1'b1, pushes[i + 1], 1'b0, 1'b0);
      else begin
        drive_a(1'b0, 8'd0, 1'b1, 1'b0);
        if (i == 4) begin
          for (int k = 0; k < 3; k++) begin
            checks++; if (a_if.read_valid !== 1'b1) begin errors++; $display("FAIL wrap_rv: got %b want 1", a_if.read_valid); end
            e = sa.pop_front();
            checks++; if (a_if.read_data !== e) begin errors++; $display("FAIL wrap_data: got %0d want %0d", a_if.read_data, e); end
            drive_a(1'b0, 8'd0, 1'b1, 1'b0);
          end
        end
        checks++; if (a_if.read_valid !== 1'b1) begin errors++; $display("FAIL wrap_rv: got %b want 1", a_if.read_valid); end
        e = sa.pop_front();
        last_rd = e;
        checks++; if (a_if.read_data !== e) begin errors++; $display("FAIL wrap_data: got %0d want %0d", a_if.read_data, e); end
      end
    end
    checks++; if (a_if.empty !== 1'b1 || a_if.count !== 3'd0) begin errors++; $display("FAIL wrap_empty: got empty=%b count=%0d want 1 0", a_if.empty, a_if.count); end
    checks++; if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow: got %b want 0", a_if.overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] e;
    for (int i = 1; i <= 4; i++) drive_a(1'b1, 8'(i), 1'b0, 1'b0);
    checks++; if (a_if.full !== 1'b1) begin errors++; $display("FAIL pp_full: got %b want 1", a_if.full); end
    drive_a(1'b1, 8'd5, 1'b1, 1'b0);
    checks++; if (a_if.read_valid !== 1'b1) begin errors++; $display("FAIL pp_rv: got %b want 1", a_if.read_valid); end
    e = sa.pop_front();
    checks++; if (a_if.read_data !== e || e !== 8'd1) begin errors++; $display("FAIL pp_data: got %0d want 1", a_if.read_data); end
    checks++; if (a_if.count !== 3'd4) begin errors++; $display("FAIL pp_count: got %0d want 4", a_if.count); end
    checks++; if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %b want 0", a_if.overflow); end
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b0, 8'd0, 1'b1, 1'b0);
      e = sa.pop_front();
      last_rd = e;
      checks++; if (a_if.read_valid !== 1'b1 || a_if.read_data !== e) begin errors++; $display("FAIL pp_drain: got rv=%b data=%0d want 1 %0d", a_if.read_valid, a_if.read_data, e); end
    end
    drive_a(1'b1, 8'd9, 1'b1, 1'b0);
    checks++; if (a_if.count !== 3'd1) begin errors++; $display("FAIL ep_count: got %0d want 1", a_if.count); end
    checks++; if (a_if.underflow !== 1'b1) begin errors++; $display("FAIL ep_underflow: got %b want 1", a_if.underflow); end
    checks++; if (a_if.read_valid !== 1'b0) begin errors++; $display("FAIL ep_rv: got %b want 0", a_if.read_valid); end
    drive_a(1'b0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic test_flush_reset();
    logic [7:0] e;
    drive_a(1'b1, 8'd7, 1'b0, 1'b0);
    drive_a(1'b1, 8'd8, 1'b0, 1'b1);
    checks++; if (a_if.count !== 3'd0 || a_if.empty !== 1'b1) begin errors++; $display("FAIL flush_count: got count=%0d empty=%b want 0 1", a_if.count, a_if.empty); end
    checks++; if (a_if.overflow !== 1'b0 || a_if.underflow !== 1'b0) begin errors++; $display("FAIL flush_sticky: got %b%b want 00", a_if.overflow, a_if.underflow); end
    checks++; if (a_if.read_data !== last_rd) begin errors++; $display("FAIL flush_hold: got %0d want %0d", a_if.read_data, last_rd); end
    drive_a(1'b0, 8'd0, 1'b1, 1'b0);
    checks++; if (a_if.read_valid !== 1'b0 || a_if.underflow !== 1'b1) begin errors++; $display("FAIL flush_not_stored: got rv=%b udf=%b want 0 1", a_if.read_valid, a_if.underflow); end
    drive_a(1'b0, 8'd0, 1'b0, 1'b1);
    drive_a(1'b1, 8'd1, 1'b0, 1'b0);
    drive_a(1'b1, 8'd2, 1'b0, 1'b0);
    drive_a(1'b0, 8'd0, 1'b1, 1'b0);
    e = sa.pop_front();
    checks++; if (a_if.read_valid !== 1'b1 || a_if.read_data !== e) begin errors++; $display("FAIL pre_rst_pop: got rv=%b data=%0d want 1 %0d", a_if.read_valid, a_if.read_data, e); end
    #2 rst = 1'b0;
    #1;
    checks++; if (a_if.count !== 3'd0 || a_if.empty !== 1'b1 || a_if.full !== 1'b0) begin errors++; $display("FAIL async_rst_count: got count=%0d empty=%b full=%b want 0 1 0", a_if.count, a_if.empty, a_if.full); end
    checks++; if (a_if.read_valid !== 1'b0 || a_if.read_data !== 8'd0) begin errors++; $display("FAIL async_rst_read: got rv=%b data=%0d want 0 0", a_if.read_valid, a_if.read_data); end
    checks++; if (a_if.almost_empty !== 1'b1 || a_if.almost_full !== 1'b0) begin errors++; $display("FAIL async_rst_almost: got ae=%b af=%b want 1 0", a_if.almost_empty, a_if.almost_full); end
    sa.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    exp_rv  = 1'b0;
    #2 rst = 1'b1;
    tick();
    checks++; if (a_if.count !== 3'd0 || a_if.underflow !== 1'b0) begin errors++; $display("FAIL post_rst: got count=%0d udf=%b want 0 0", a_if.count, a_if.underflow); end
  endtask

  task automatic test_fwft();
    bit wr;
    bit rd;
    bit pop_ok;
    bit push_ok;
    logic [7:0] d;
    b_if.write_en   = 1'b1;
    b_if.write_data = 8'd11;
    tick();
    b_if.write_en = 1'b0;
    sb.push_back(8'd11);
    checks++; if (b_if.read_valid !== 1'b1 || b_if.read_data !== 8'd11) begin errors++; $display("FAIL fwft_first: got rv=%b data=%0d want 1 11", b_if.read_valid, b_if.read_data); end
    checks++; if (b_if.count !== 3'd1) begin errors++; $display("FAIL fwft_first_count: got %0d want 1", b_if.count); end
    for (int n = 0; n < 1000; n++) begin
      wr = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      rd = (n < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      pop_ok  = rd && (sb.size() > 0);
      push_ok = wr && ((sb.size() < 5) || pop_ok);
      b_if.write_en   = wr;
      b_if.write_data = d;
      b_if.read_en    = rd;
      tick();
      b_if.write_en = 1'b0;
      b_if.read_en  = 1'b0;
      if (pop_ok)  void'(sb.pop_front());
      if (push_ok) sb.push_back(d);
      checks++; if (int'(b_if.count) !== sb.size()) begin errors++; $display("FAIL fwft_count: got %0d want %0d at step %0d", b_if.count, sb.size(), n); end
      checks++; if (b_if.full !== (sb.size() == 5)) begin errors++; $display("FAIL fwft_full: got %b want %b at step %0d", b_if.full, (sb.size() == 5), n); end
      if (sb.size() > 0) begin
        checks++; if (b_if.read_valid !== 1'b1 || b_if.read_data !== sb[0]) begin errors++; $display("FAIL fwft_head: got rv=%b data=%0d want 1 %0d at step %0d", b_if.read_valid, b_if.read_data, sb[0], n); end
      end else begin
        checks++; if (b_if.read_valid !== 1'b0 || b_if.read_data !== 8'd0) begin errors++; $display("FAIL fwft_empty: got rv=%b data=%0d want 0 0 at step %0d", b_if.read_valid, b_if.read_data, n); end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    a_if.flush = 1'b0; a_if.write_en = 1'b0; a_if.write_data = '0; a_if.read_en = 1'b0;
    b_if.flush = 1'b0; b_if.write_en = 1'b0; b_if.write_data = '0; b_if.read_en = 1'b0;
    exp_rv = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0; last_rd = '0;
    repeat (2) tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_fill_overflow();
    test_underflow();
    test_wrap();
    test_full_push_pop();
    test_flush_reset();
    test_fwft();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
